// File: rtl/mips_pkg.sv
// Shared ISA definitions: opcode encodings, bubble opcode, instruction
// word layout and the register-writing classification used by decode,
// execution and writeback.
package mips_pkg;

    // ALU register-register group (000xxx)
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_CMP = 6'b000011;
    localparam logic [5:0] OP_OR  = 6'b000100;
    localparam logic [5:0] OP_XOR = 6'b000101;
    localparam logic [5:0] OP_NOT = 6'b000110;
    localparam logic [5:0] OP_MOV = 6'b000111;

    // ALU immediate group (001xxx), data_in carries imm
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_SBI = 6'b001001;
    localparam logic [5:0] OP_ANI = 6'b001010;
    localparam logic [5:0] OP_CPI = 6'b001011;
    localparam logic [5:0] OP_ORI = 6'b001100;
    localparam logic [5:0] OP_XRI = 6'b001101;
    localparam logic [5:0] OP_MVI = 6'b001110;
    localparam logic [5:0] OP_LUI = 6'b001111;

    // Control, memory and I/O
    localparam logic [5:0] OP_NOP = 6'b010000;
    localparam logic [5:0] OP_HLT = 6'b010001;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_ST  = 6'b010101;
    localparam logic [5:0] OP_IN  = 6'b010110;
    localparam logic [5:0] OP_OUT = 6'b010111;

    // Shift/rotate group
    localparam logic [5:0] OP_SHL = 6'b011001;
    localparam logic [5:0] OP_SHR = 6'b011010;
    localparam logic [5:0] OP_ROT = 6'b011011;

    // Jumps
    localparam logic [5:0] OP_JMP = 6'b011100;
    localparam logic [5:0] OP_JZ  = 6'b011101;
    localparam logic [5:0] OP_JNZ = 6'b011110;

    // Bubble opcode: zero result, flags untouched downstream
    localparam logic [5:0] NOP_OP = 6'b111111;

    // Fetch-side instruction word layout
    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [1:0]  rsvd;
        logic [15:0] imm;
    } instr_t;

    // True for every opcode that commits a result to R[rd]
    function automatic logic writes_reg(input logic [5:0] op);
        logic w;
        w = 1'b0;
        if (op[5:3] == 3'b000 && op[2:0] != 3'b011) w = 1'b1;
        if (op[5:3] == 3'b001 && op[2:0] != 3'b011) w = 1'b1;
        if (op == OP_LD || op == OP_IN)              w = 1'b1;
        if (op == OP_SHL || op == OP_SHR || op == OP_ROT) w = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/decode_block_register_file.sv
// NREG x DW register file: two asynchronous read ports with write-first
// bypass, one synchronous write port, asynchronous active-low clear.
module register_file #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [NREG-1:0][DW-1:0] regs;

    // One storage word per register; cleared on reset, written on we
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                regs[g] <= '0;
            else if (we && waddr == AW'(g))
                regs[g] <= wdata;
        end
    end

    // Reads see a same-cycle write so decode never stalls on a landing result
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (we && waddr == raddr_a) rdata_a = wdata;
        if (we && waddr == raddr_b) rdata_b = wdata;
    end

endmodule

// File: rtl/decode_block.sv
// Decode / operand-fetch stage: splits the instruction word, reads two
// operands, tracks outstanding register writes and stops after HLT.
module decode_block
    import mips_pkg::*;
#(
    parameter int         DW     = 16,
    parameter int         NREG   = 16,
    parameter logic [5:0] NOP_OP = 6'b111111
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [DW-1:0] io_in,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [3:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [DW-1:0] data_in,
    output logic [5:0]    op_dec,
    output logic [3:0]    rd_dec,
    output logic          halted
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    instr_t          iw;
    logic [0:0]      state;
    logic [NREG-1:0] sb, sb_nxt;
    logic [DW-1:0]   rd_val, rs_val, din_sel;
    logic            hazard, accept;
    logic            unused_rsvd;

    assign iw          = instr_t'(instr);
    assign unused_rsvd = ^iw.rsvd;

    register_file #(.DW(DW), .NREG(NREG)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (iw.rd),
        .raddr_b (iw.rs),
        .rdata_a (rd_val),
        .rdata_b (rs_val)
    );

    // Stall while rd or rs has a result in flight, unless it lands this cycle
    always_comb begin
        hazard = 1'b0;
        if (sb[iw.rd] && !(wb_en && wb_addr == iw.rd)) hazard = 1'b1;
        if (sb[iw.rs] && !(wb_en && wb_addr == iw.rs)) hazard = 1'b1;
    end

    assign instr_ready = (state == ST_RUN) && !flush && !hazard;
    assign accept      = instr_valid && instr_ready;
    assign halted      = (state == ST_HALT);

    // Third operand: port input for IN, immediate for the 001xxx group
    always_comb begin
        din_sel = '0;
        if (iw.op == OP_IN)
            din_sel = io_in;
        else if (iw.op[5:3] == 3'b001)
            din_sel = DW'(iw.imm);
    end

    // Scoreboard update: clears first so a same-cycle set wins
    always_comb begin
        sb_nxt = sb;
        if (wb_en)
            sb_nxt[wb_addr] = 1'b0;
        if (flush && writes_reg(op_dec))
            sb_nxt[rd_dec] = 1'b0;
        if (accept && writes_reg(iw.op))
            sb_nxt[iw.rd] = 1'b1;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sb <= '0;
        else        sb <= sb_nxt;
    end

    // RUN -> HALT once HLT issues; only reset leaves HALT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_RUN;
        else if (state == ST_RUN && accept && iw.op == OP_HLT && !flush)
            state <= ST_HALT;
    end

    // Output register: accepted instruction, else a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A       <= '0;
            B       <= '0;
            data_in <= '0;
            op_dec  <= NOP_OP;
            rd_dec  <= '0;
        end else if (accept) begin
            A       <= rd_val;
            B       <= rs_val;
            data_in <= din_sel;
            op_dec  <= iw.op;
            rd_dec  <= iw.rd;
        end else begin
            A       <= '0;
            B       <= '0;
            data_in <= '0;
            op_dec  <= NOP_OP;
            rd_dec  <= '0;
        end
    end

endmodule

// File: doc/decode_block.md
# decode_block

Decode/operand-fetch stage directly upstream of the execution stage. It accepts 32-bit instruction words from fetch and splits out the opcode and immediate. It reads two operands from a 16x16 register file and registers `A`, `B`, `data_in` and `op_dec` for the execution stage. It also owns the register-file writeback port, tracks outstanding writes with a scoreboard, and stops issuing once a halt instruction has been issued.

## Interface
Parameters:
- `DW`, 16: data width.
- `NREG`, 16: number of registers.
- `NOP_OP`, 6'b111111: bubble opcode. Execution produces a zero result for it and leaves the flags unchanged.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low.
- `instr`  input  32  instruction word: [31:26] opcode, [25:22] rd, [21:18] rs, [17:16] reserved, [15:0] imm.
- `instr_valid`  input  1  fetch offers `instr`.
- `instr_ready`  output  1  decode accepts `instr` this cycle.
- `io_in`  input  DW  external input port, used by IN.
- `flush`  input  1  taken jump; kills the instruction held in the output register.
- `wb_en`  input  1  register write enable.
- `wb_addr`  input  4  register write address.
- `wb_data`  input  DW  register write data.
- `A`  output  DW  R[rd], registered.
- `B`  output  DW  R[rs], registered.
- `data_in`  output  DW  immediate or `io_in`, registered.
- `op_dec`  output  6  opcode, registered.
- `rd_dec`  output  4  destination tag, registered.
- `halted`  output  1  high in the HALT state.

## Operation
- Handshake: an instruction is accepted on a rising edge when `instr_valid && instr_ready`.
- `instr_ready = (state==RUN) && !flush && !hazard`.
- Hazard: set when `sb[rd]` or `sb[rs]` is set. Each check is suppressed when `wb_en` writes that same register in the same cycle.
- Operand read: `A = R[rd]`, `B = R[rs]`. When `wb_en && wb_addr` matches the register being read, the value is `wb_data` (write-first bypass).
- `data_in` selection:
  - `io_in` for IN (010110).
  - `imm` for opcodes 001xxx.
  - 0 otherwise.
- Register-writing ops: 000000–000111 except 000011; 001000–001111 except 001011; 010100 (LD); 010110 (IN); 011001–011011.
- Scoreboard `sb[NREG-1:0]`:
  - On accepting a register-writing op, `sb[rd]` is set.
  - On `wb_en`, `sb[wb_addr]` is cleared.
  - If both events hit the same register in one cycle, set wins.
- Flush: the output register loads a bubble. If the killed instruction was register-writing, its `sb[rd_dec]` bit is cleared.
- Bubble: whenever nothing is accepted, the output register loads `op_dec=NOP_OP`, `A=B=data_in=0`, `rd_dec=0`.
- State machine, states RUN and HALT:
  - RUN → HALT when HLT (010001) is accepted. The HLT itself is issued.
  - HALT is left only by reset. In HALT, `instr_ready=0` and bubbles are issued.
  - A flush arriving in the same cycle as the HLT acceptance keeps the state at RUN.

## Timing
- Latency: one cycle. An instruction accepted at edge N is presented at the outputs after edge N.
- A writeback at edge N is visible to a read in cycle N through the bypass, and stored in the file after edge N.
- Reset (asynchronous, active-low):
  - All registers = 0, `sb = 0`, state = RUN.
  - Outputs: `A=B=data_in=0`, `op_dec=NOP_OP`, `rd_dec=0`, `halted=0`.
  - `instr_ready` follows its equation, so it is high after reset deassertion when no flush is present.
- Reset asserted mid-operation clears everything immediately, including any pending scoreboard bits.
- Writes to register 0 are allowed; it is an ordinary register.
- Reserved bits [17:16] are ignored.

## Structure
- Shared package `mips_pkg` holds:
  - opcode localparams (ADD…JNZ);
  - `NOP_OP`;
  - the `writes_reg(op)` function, reused by execution and writeback.
- Sub-module `register_file`: NREG x DW, two asynchronous read ports, one synchronous write port, write-first bypass, asynchronous active-low clear.
- Scoreboard, state machine and output register live in `decode_block`.

## Test plan
- Reset, then ADI with rd=2, imm=0x0005 → after one edge: `op_dec=001000`, `data_in=0x0005`, `rd_dec=2`, `sb[2]=1`.
- Issue ADD r2,r3 while `sb[2]=1` and no writeback → `instr_ready=0`, bubble issued. Then `wb_en` with addr 2, data 0x1234 → instruction accepted that cycle with `A=0x1234`.
- IN with rd=4 and `io_in=0xBEEF` → `data_in=0xBEEF`, `sb[4]=1`. Then NOT r5,r6 → `data_in=0`, `B=R[6]`.
- Accept MVI to rd=7, then assert `flush` next cycle → bubble issued, `sb[7]=0`, `instr_ready=0` during the flush.
- Accept HLT → `halted=1` after the edge and `op_dec=010001` for one cycle. Then `instr_ready=0` and NOP_OP is issued indefinitely. Assert reset → `halted=0` and all registers read 0.
